// File: rtl/cve2_csr_arbiter.sv
// Two-port (core/debug) arbiter for a small bank of cve2_csr registers.
// Each access is an atomic read-modify-write sequenced over IDLE -> EXEC -> RESP.

module cve2_csr #(
  parameter int unsigned           Width      = 32,
  parameter bit                    ShadowCopy = 1'b0,
  parameter logic [Width-1:0]      ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] wr_data_i,
  input  logic             wr_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             rd_error_o
);
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rdata_q <= ResetValue;
    else if (wr_en_i) rdata_q <= wr_data_i;
  end

  assign rd_data_o = rdata_q;

  // Shadow holds the inverted value; any disagreement is an integrity error.
  if (ShadowCopy) begin : g_shadow
    logic [Width-1:0] shadow_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      shadow_q <= ~ResetValue;
      else if (wr_en_i) shadow_q <= ~wr_data_i;
    end
    assign rd_error_o = (rdata_q != ~shadow_q);
  end else begin : g_no_shadow
    assign rd_error_o = 1'b0;
  end
endmodule

module cve2_csr_arbiter #(
  parameter int unsigned      NumRegs    = 8,
  parameter int unsigned      Width      = 32,
  parameter bit               ShadowCopy = 1'b0,
  parameter logic [Width-1:0] ResetValue = '0,
  localparam int unsigned     AW         = $clog2(NumRegs)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             core_req_i,
  input  logic [AW-1:0]    core_addr_i,
  input  logic [1:0]       core_op_i,
  input  logic [Width-1:0] core_wdata_i,
  output logic             core_gnt_o,
  output logic             core_rvalid_o,
  output logic [Width-1:0] core_rdata_o,
  output logic             core_err_o,
  input  logic             dbg_req_i,
  input  logic [AW-1:0]    dbg_addr_i,
  input  logic [1:0]       dbg_op_i,
  input  logic [Width-1:0] dbg_wdata_i,
  output logic             dbg_gnt_o,
  output logic             dbg_rvalid_o,
  output logic [Width-1:0] dbg_rdata_o,
  output logic             dbg_err_o,
  output logic             alert_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [1:0]       state_q, state_d;
  logic             last_dbg_q, last_dbg_d;
  logic             sel_dbg_q, sel_dbg_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [1:0]       op_q, op_d;
  logic [Width-1:0] wdata_q, wdata_d;
  logic [Width-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [Width-1:0] bank_rdata [NumRegs];
  logic [NumRegs-1:0] bank_err;
  logic [Width-1:0] old_val, new_val;
  logic             rd_err, in_range, acc_err, bank_we;
  logic             core_win, dbg_win;

  // Round-robin: core wins a tie unless it was the last one served.
  assign core_win = core_req_i && (!dbg_req_i || last_dbg_q);
  assign dbg_win  = dbg_req_i && !core_win;

  assign core_gnt_o = (state_q == IDLE) && core_win;
  assign dbg_gnt_o  = (state_q == IDLE) && dbg_win;

  always_comb begin
    old_val = '0;
    rd_err  = 1'b0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (addr_q == AW'(i)) begin
        old_val = bank_rdata[i];
        rd_err  = bank_err[i];
      end
    end
  end

  assign in_range = 32'(addr_q) < NumRegs;
  assign acc_err  = !in_range || rd_err;

  always_comb begin
    new_val = old_val;
    unique case (op_q)
      OP_WRITE: new_val = wdata_q;
      OP_SET:   new_val = old_val | wdata_q;
      OP_CLEAR: new_val = old_val & ~wdata_q;
      default:  new_val = old_val;
    endcase
  end

  // Zero-mask set/clear is a no-op and must not touch the bank.
  assign bank_we = (state_q == EXEC) && !acc_err &&
                   ((op_q == OP_WRITE) || (op_q[1] && (wdata_q != '0)));

  for (genvar g = 0; g < NumRegs; g++) begin : g_bank
    cve2_csr #(
      .Width     (Width),
      .ShadowCopy(ShadowCopy),
      .ResetValue(ResetValue)
    ) u_csr (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_data_i (new_val),
      .wr_en_i   (bank_we && (addr_q == AW'(g))),
      .rd_data_o (bank_rdata[g]),
      .rd_error_o(bank_err[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    last_dbg_d = last_dbg_q;
    sel_dbg_d  = sel_dbg_q;
    addr_d     = addr_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (core_win || dbg_win) begin
          state_d    = EXEC;
          last_dbg_d = dbg_win;
          sel_dbg_d  = dbg_win;
          addr_d     = dbg_win ? dbg_addr_i  : core_addr_i;
          op_d       = dbg_win ? dbg_op_i    : core_op_i;
          wdata_d    = dbg_win ? dbg_wdata_i : core_wdata_i;
        end
      end
      EXEC: begin
        rdata_d = acc_err ? '0 : old_val;
        err_d   = acc_err;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_dbg_q <= 1'b1;
      sel_dbg_q  <= 1'b0;
      addr_q     <= '0;
      op_q       <= OP_READ;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dbg_q <= last_dbg_d;
      sel_dbg_q  <= sel_dbg_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign core_rvalid_o = (state_q == RESP) && !sel_dbg_q;
  assign dbg_rvalid_o  = (state_q == RESP) && sel_dbg_q;
  assign core_rdata_o  = core_rvalid_o ? rdata_q : '0;
  assign dbg_rdata_o   = dbg_rvalid_o  ? rdata_q : '0;
  assign core_err_o    = core_rvalid_o && err_q;
  assign dbg_err_o     = dbg_rvalid_o  && err_q;
  assign alert_o       = (state_q == EXEC) && rd_err;
endmodule

// File: tb/tb_cve2_csr_arbiter.sv
// Self-checking bench for cve2_csr_arbiter: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.

module tb_cve2_csr_arbiter;
  localparam int unsigned NREGS = 6;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, ST = 2'b10, CL = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0, dbg_req = 1'b0;
  logic [2:0]  core_addr = '0, dbg_addr = '0;
  logic [1:0]  core_op = '0, dbg_op = '0;
  logic [31:0] core_wdata = '0, dbg_wdata = '0;
  logic        core_gnt, core_rvalid, core_err, dbg_gnt, dbg_rvalid, dbg_err, alert;
  logic [31:0] core_rdata, dbg_rdata;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cve2_csr_arbiter #(
    .NumRegs   (NREGS),
    .Width     (32),
    .ShadowCopy(1'b1),
    .ResetValue(32'h0)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .core_req_i   (core_req),
    .core_addr_i  (core_addr),
    .core_op_i    (core_op),
    .core_wdata_i (core_wdata),
    .core_gnt_o   (core_gnt),
    .core_rvalid_o(core_rvalid),
    .core_rdata_o (core_rdata),
    .core_err_o   (core_err),
    .dbg_req_i    (dbg_req),
    .dbg_addr_i   (dbg_addr),
    .dbg_op_i     (dbg_op),
    .dbg_wdata_i  (dbg_wdata),
    .dbg_gnt_o    (dbg_gnt),
    .dbg_rvalid_o (dbg_rvalid),
    .dbg_rdata_o  (dbg_rdata),
    .dbg_err_o    (dbg_err),
    .alert_o      (alert)
  );

  typedef struct {
    bit          dbg;
    logic [2:0]  addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    core_req = 1'b0;
    dbg_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_gnt"},    {core_gnt, dbg_gnt}, 0);
    chk({nm, "_rvalid"}, {core_rvalid, dbg_rvalid}, 0);
    chk({nm, "_crdata"}, core_rdata, 0);
    chk({nm, "_drdata"}, dbg_rdata, 0);
    chk({nm, "_err"},    {core_err, dbg_err}, 0);
    chk({nm, "_alert"},  alert, 0);
  endtask

  // One access on one port: grant in N, alert checked in N+1, response in N+2.
  task automatic txn(input vec_t v, input bit exp_alert);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    if (v.dbg) begin
      dbg_req = 1'b1; dbg_addr = v.addr; dbg_op = v.op; dbg_wdata = v.wdata;
    end else begin
      core_req = 1'b1; core_addr = v.addr; core_op = v.op; core_wdata = v.wdata;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = v.dbg ? dbg_gnt : core_gnt;
    end
    chk("txn_gnt", got, 1);
    if (!got) begin
      core_req = 1'b0; dbg_req = 1'b0;
      return;
    end
    chk("txn_gnt_other", v.dbg ? core_gnt : dbg_gnt, 0);
    chk("txn_alert_n", alert, 0);
    @(posedge clk);
    #1;
    if (v.dbg) dbg_req = 1'b0; else core_req = 1'b0;
    @(negedge clk);
    chk("txn_rvalid_n1", {core_rvalid, dbg_rvalid}, 0);
    chk("txn_gnt_n1", {core_gnt, dbg_gnt}, 0);
    chk("txn_alert_n1", alert, exp_alert);
    @(negedge clk);
    chk("txn_rvalid", v.dbg ? dbg_rvalid : core_rvalid, 1);
    chk("txn_rvalid_other", v.dbg ? core_rvalid : dbg_rvalid, 0);
    chk("txn_rdata", v.dbg ? dbg_rdata : core_rdata, v.rdata);
    chk("txn_err", v.dbg ? dbg_err : core_err, v.err);
    chk("txn_alert_n2", alert, 0);
  endtask

  // Transaction-level reference model for the randomized run.
  logic [31:0] m_regs [NREGS];

  task automatic model_access(input logic [2:0] a, input logic [1:0] op, input logic [31:0] wd,
                              output logic [31:0] rd, output bit er);
    er = (int'(a) >= NREGS);
    rd = er ? 32'h0 : m_regs[a];
    if (!er) begin
      case (op)
        WR: m_regs[a] = wd;
        ST: m_regs[a] = m_regs[a] | wd;
        CL: m_regs[a] = m_regs[a] & ~wd;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] rnd_data();
    return ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [31:0] m_rd, pend_rdata;
    bit m_er, pend_dbg, pend_err, m_last_dbg, exp_gc, exp_gd, drop_c, drop_d;
    int wait_cnt, ng, last_cyc;
    bit exp_turn;

    vecs.push_back('{1'b0, 3'd3, WR, 32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'd3, RD, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 3'd2, WR, 32'h000000F0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 3'd2, ST, 32'h0000000F, 32'h000000F0, 1'b0});
    vecs.push_back('{1'b1, 3'd2, CL, 32'h00000030, 32'h000000FF, 1'b0});
    vecs.push_back('{1'b1, 3'd2, RD, 32'h0,        32'h000000CF, 1'b0});
    vecs.push_back('{1'b0, 3'd5, ST, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'd7, WR, 32'h00001234, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 3'd6, WR, 32'h0000FFFF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 3'd0, RD, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'd1, RD, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b1, 3'd2, RD, 32'h0,        32'h000000CF, 1'b0});
    vecs.push_back('{1'b0, 3'd3, RD, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 3'd4, RD, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'd5, RD, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'd7, RD, 32'h0,        32'h0,        1'b1});

    do_reset();
    @(negedge clk);
    chk_idle_outputs("reset");

    foreach (vecs[i]) txn(vecs[i], 1'b0);

    // Shadow integrity: corrupt reg 1's shadow, then a write must be refused.
    v = '{1'b0, 3'd1, WR, 32'h00000055, 32'h0, 1'b0};
    txn(v, 1'b0);
    force dut.g_bank[1].u_csr.g_shadow.shadow_q = 32'hFFFFFFAB;
    v = '{1'b0, 3'd1, WR, 32'h000000AA, 32'h0, 1'b1};
    txn(v, 1'b1);
    chk("shadow_reg_kept", dut.g_bank[1].u_csr.rd_data_o, 32'h00000055);
    release dut.g_bank[1].u_csr.g_shadow.shadow_q;

    // Reset during EXEC of a write aborts it.
    do_reset();
    @(posedge clk);
    #1;
    core_req = 1'b1; core_addr = 3'd4; core_op = WR; core_wdata = 32'h12345678;
    @(negedge clk);
    chk("rst_mid_gnt", core_gnt, 1);
    @(posedge clk);
    #1;
    core_req = 1'b0;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_rvalid", {core_rvalid, dbg_rvalid}, 0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rst_release");
    v = '{1'b0, 3'd4, RD, 32'h0, 32'h0, 1'b0};
    txn(v, 1'b0);

    // Simultaneous requests: alternate core, dbg, core, spaced 3 cycles.
    do_reset();
    @(posedge clk);
    #1;
    core_req = 1'b1; core_addr = 3'd0; core_op = RD; core_wdata = '0;
    dbg_req  = 1'b1; dbg_addr  = 3'd1; dbg_op  = RD; dbg_wdata  = '0;
    ng = 0; last_cyc = 0; exp_turn = 1'b0;
    for (int cyc = 0; cyc < 20 && ng < 3; cyc++) begin
      @(negedge clk);
      if (core_gnt || dbg_gnt) begin
        chk("arb_one_gnt", {core_gnt, dbg_gnt} == 2'b11, 0);
        chk("arb_turn_is_dbg", dbg_gnt, exp_turn);
        if (ng > 0) chk("arb_gap", cyc - last_cyc, 3);
        exp_turn = ~exp_turn;
        last_cyc = cyc;
        ng++;
      end
    end
    chk("arb_grants", ng, 3);
    core_req = 1'b0; dbg_req = 1'b0;
    repeat (4) @(posedge clk);

    // Randomized run against the transaction-level model.
    do_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 32'h0;
    m_last_dbg = 1'b1;
    wait_cnt = -1;
    pend_dbg = 1'b0; pend_rdata = '0; pend_err = 1'b0;
    drop_c = 1'b0; drop_d = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk);
      #1;
      if (drop_c) core_req = 1'b0;
      if (drop_d) dbg_req = 1'b0;
      if (!core_req && $urandom_range(0, 2) == 0) begin
        core_req = 1'b1; core_addr = 3'($urandom_range(0, 7));
        core_op = 2'($urandom); core_wdata = rnd_data();
      end
      if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1'b1; dbg_addr = 3'($urandom_range(0, 7));
        dbg_op = 2'($urandom); dbg_wdata = rnd_data();
      end
      @(negedge clk);
      exp_gc = 1'b0; exp_gd = 1'b0;
      if (wait_cnt < 0) begin
        if (core_req && dbg_req) begin
          exp_gc = m_last_dbg; exp_gd = !m_last_dbg;
        end else begin
          exp_gc = core_req; exp_gd = dbg_req;
        end
      end
      chk("rnd_core_gnt", core_gnt, exp_gc);
      chk("rnd_dbg_gnt", dbg_gnt, exp_gd);
      chk("rnd_core_rvalid", core_rvalid, (wait_cnt == 0) && !pend_dbg);
      chk("rnd_dbg_rvalid", dbg_rvalid, (wait_cnt == 0) && pend_dbg);
      chk("rnd_core_rdata", core_rdata, ((wait_cnt == 0) && !pend_dbg) ? pend_rdata : 32'h0);
      chk("rnd_dbg_rdata", dbg_rdata, ((wait_cnt == 0) && pend_dbg) ? pend_rdata : 32'h0);
      chk("rnd_core_err", core_err, (wait_cnt == 0) && !pend_dbg && pend_err);
      chk("rnd_dbg_err", dbg_err, (wait_cnt == 0) && pend_dbg && pend_err);
      chk("rnd_alert", alert, 0);
      if (wait_cnt >= 0) wait_cnt--;
      drop_c = exp_gc; drop_d = exp_gd;
      if (exp_gc) model_access(core_addr, core_op, core_wdata, m_rd, m_er);
      if (exp_gd) model_access(dbg_addr, dbg_op, dbg_wdata, m_rd, m_er);
      if (exp_gc || exp_gd) begin
        pend_dbg = exp_gd; pend_rdata = m_rd; pend_err = m_er;
        m_last_dbg = exp_gd;
        wait_cnt = 1;
      end
    end
    core_req = 1'b0; dbg_req = 1'b0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cve2_csr_arbiter.md
# cve2_csr_arbiter

Two-port access controller for a small bank of `cve2_csr` registers. It lets the core pipeline and the debug module share the bank without conflicts. The block arbitrates between the two requesters and sequences each access as an atomic read-modify-write (read, set, clear or write) over a fixed three-state FSM. It returns the old register value and an error flag. Shadow-copy integrity errors are reported to the requester and also raised as a separate alert.

## Interface
Parameters:
- `NumRegs`, 8: number of registers in the bank; must be 2..16.
- `Width`, 32: register width.
- `ShadowCopy`, 1'b0: passed to every bank register; enables integrity checking.
- `ResetValue`, '0: reset value of every bank register.

Ports (AW = $clog2(NumRegs)):
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `core_req_i` / `dbg_req_i` in 1: access request. Address, operation and write data must stay stable until grant.
- `core_addr_i` / `dbg_addr_i` in AW: register index.
- `core_op_i` / `dbg_op_i` in 2: operation. 00 = read, 01 = write, 10 = set bits, 11 = clear bits.
- `core_wdata_i` / `dbg_wdata_i` in Width: write data or bit mask.
- `core_gnt_o` / `dbg_gnt_o` out 1: request accepted this cycle. Combinational; asserted only in IDLE.
- `core_rvalid_o` / `dbg_rvalid_o` out 1: one-cycle response strobe.
- `core_rdata_o` / `dbg_rdata_o` out Width: register value before the access. Valid with rvalid, otherwise 0.
- `core_err_o` / `dbg_err_o` out 1: access error. Valid with rvalid, otherwise 0.
- `alert_o` out 1: one-cycle pulse when a shadow mismatch is detected.

## Operation
- The bank is `NumRegs` instances of `cve2_csr`. The write enable of the addressed instance is driven only from the EXEC state.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any request is present, grant exactly one requester.
  - Latch that requester's address, operation, write data and identity.
  - Go to EXEC. With no request, stay in IDLE.
- Arbitration is round-robin using a last-granted flag. The flag resets to "dbg", so core wins the first tie. A lone requester always wins.
- EXEC:
  - Capture `old` = bank read data at the latched address.
  - Compute `err` = (address >= NumRegs) OR read-error of the addressed register.
  - Compute `new`: write gives wdata; set gives old | wdata; clear gives old & ~wdata.
  - Assert write enable only if !err AND (op == write, OR (op is set/clear AND wdata != 0)). A read never writes.
  - Register rdata = err ? 0 : old. Register err.
  - Pulse `alert_o` if a shadow read-error occurred. Go to RESP.
- RESP:
  - Assert rvalid, rdata and err to the latched requester only.
  - Return to IDLE. A new grant is possible in the next cycle.
- Out-of-range address: err = 1, rdata = 0, no write, no alert.
- Requests arriving during EXEC or RESP are not granted and wait. They are not dropped.

## Timing
- Grant in cycle N. Bank update at the clock edge ending cycle N+1. rvalid in cycle N+2.
- Maximum throughput is one access every 3 cycles. Back-to-back: next grant is possible in cycle N+3.
- A read issued after a write observes the new value. The write commits before the read's EXEC.
- Reset values of all outputs are 0, including gnt, rvalid, rdata, err and alert_o. The bank resets to `ResetValue` and the FSM to IDLE.
- Reset asserted mid-access aborts it. No rvalid is issued, and the write is lost if reset arrives before the N+1 edge.
- Simultaneous requests in IDLE: exactly one gnt. The loser keeps its request asserted and is granted at N+3, since it is the round-robin winner then.

## Test plan
- Reset, then core writes 0xDEADBEEF to reg 3 -> gnt at N, core_rvalid at N+2 with rdata 0. A subsequent read of reg 3 returns 0xDEADBEEF with err = 0.
- Reg 2 = 0x0000_00F0. dbg sets mask 0x0F, then clears mask 0x30 -> rdata responses 0xF0 then 0xFF; reg 2 final value 0xCF.
- Core and dbg both request in the same cycle, repeatedly -> grants alternate core, dbg, core. No response is ever routed to the wrong port.
- NumRegs = 6, access to address 7 with a write -> err = 1, rdata = 0, no register changes, alert_o stays 0.
- ShadowCopy = 1, force a bit flip in reg 1's shadow flop, then write reg 1 -> err = 1, alert_o pulses for one cycle in EXEC, reg 1 keeps its value.
- Assert rst_ni low in the EXEC cycle of a write -> no rvalid, the register holds `ResetValue`, and the FSM is in IDLE after reset release.
